// File: rtl/booth_mul_pkg.sv
// ---------------------------------------------------------------------------
// booth_mul_pkg
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_e       : controller states (IDLE, CALC, DONE)
//   booth_digit_t : recoded Booth digit as {neg, one, two}
//   booth_iters() : number of CALC iterations for a given operand width
//   booth_decode(): 3-bit overlapping multiplier window -> Booth digit
// ---------------------------------------------------------------------------
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit value is (neg ? -1 : +1) * (one ? 1 : two ? 2 : 0)
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Operands are extended by two bits, so WIDTH+2 multiplier bits are
  // consumed two at a time.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

  // Window is {y[2i+1], y[2i], y[2i-1]}. 000 and 111 both decode to zero
  // with neg cleared, so a zero digit never produces a negated magnitude.
  function automatic booth_digit_t booth_decode(input logic [2:0] window);
    booth_digit_t d;
    d = '0;
    case (window)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011: d.two = 1'b1;
      3'b100: begin
        d.neg = 1'b1;
        d.two = 1'b1;
      end
      3'b101, 3'b110: begin
        d.neg = 1'b1;
        d.one = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// ---------------------------------------------------------------------------
// booth_r4_enc
// Radix-4 Booth partial-product generator.
// Ports:
//   window_i [2:0]       : overlapping multiplier window {y[2i+1],y[2i],y[2i-1]}
//   mcand_i  [WIDTH+1:0] : extended multiplicand X (two's complement)
//   pp_o     [WIDTH+2:0] : digit * X, one of -2X, -X, 0, +X, +2X
// ---------------------------------------------------------------------------
module booth_r4_enc
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window_i,
  input  logic [WIDTH+1:0] mcand_i,
  output logic [WIDTH+2:0] pp_o
);

  booth_digit_t     digit;
  logic [WIDTH+2:0] mag;

  // Select |digit| * X one bit wider than X so that 2X fits, then negate by
  // inverting and adding the neg bit as carry-in.
  always_comb begin
    digit = booth_decode(window_i);
    mag   = '0;
    if (digit.one) begin
      mag = {mcand_i[WIDTH+1], mcand_i};
    end else if (digit.two) begin
      mag = {mcand_i, 1'b0};
    end
    pp_o = (mag ^ {(WIDTH+3){digit.neg}}) + {{(WIDTH+2){1'b0}}, digit.neg};
  end

endmodule

// File: rtl/booth_mul_r4.sv
// ---------------------------------------------------------------------------
// booth_mul_r4
// Iterative radix-4 Booth multiplier, one Booth digit retired per cycle.
// Signed and unsigned products share the datapath: both operands are
// extended to WIDTH+2 bits (sign- or zero-extended by mul_signed).
// Ports:
//   clk, resetn          : clock and asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (src1, src2, mul_signed)
//   out_valid / out_ready: result handshake
//   result [2*WIDTH-1:0] : full product, held until the next completion
// Optional build macro:
//   BOOTH_MUL_EARLY_TERM_EN : finish as soon as the remaining multiplier
//                             bits can only produce zero digits.
// ---------------------------------------------------------------------------
module booth_mul_r4
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mul_signed,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int K  = booth_iters(WIDTH);
  localparam int EW = WIDTH + 2;        // extended operand width
  localparam int HW = WIDTH + 4;        // running partial-sum width
  localparam int AW = HW + EW;          // partial sum plus retired low bits
  localparam int CW = $clog2(K + 1);

  state_e               state_q;
  logic [EW-1:0]        mcand_q;
  logic [EW-1:0]        mplr_q;
  logic                 ovl_q;
  logic [AW-1:0]        acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 accept;
  logic [EW-1:0]        mcand_ext;
  logic [EW-1:0]        mplr_ext;
  logic [2:0]           window;
  logic [EW:0]          pp;
  logic [HW-1:0]        sum;
  logic [AW-1:0]        acc_step;
  logic [AW-1:0]        acc_d;
  logic                 last_iter;
  logic                 finish;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  assign mcand_ext = mul_signed ? {{2{src1[WIDTH-1]}}, src1} : {2'b00, src1};
  assign mplr_ext  = mul_signed ? {{2{src2[WIDTH-1]}}, src2} : {2'b00, src2};

  assign window = {mplr_q[1:0], ovl_q};

  booth_r4_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .window_i (window),
    .mcand_i  (mcand_q),
    .pp_o     (pp)
  );

  // The upper part of acc_q is the running partial sum; after every digit
  // the whole register shifts right by two, so retired product bits collect
  // at the bottom and after K shifts acc_q holds the exact product.
  assign sum       = acc_q[AW-1 -: HW] + {pp[EW], pp};
  assign acc_step  = AW'($signed({sum, acc_q[EW-1:0]}) >>> 2);
  assign last_iter = (cnt_q == CW'(K - 1));

`ifdef BOOTH_MUL_EARLY_TERM_EN
  logic          early;
  logic [CW-1:0] rem;
  logic [CW:0]   shamt;

  // mplr_q[EW-1:1] are the bits the next windows would see (upper bits plus
  // the next overlap bit); if they are uniform every later digit is zero, so
  // the outstanding shifts are applied in one go to keep the result exact.
  assign early = (&mplr_q[EW-1:1]) | ~(|mplr_q[EW-1:1]);
  assign rem   = CW'(K) - cnt_q;
  assign shamt = {rem, 1'b0};
  assign acc_d  = early ? AW'($signed({sum, acc_q[EW-1:0]}) >>> shamt) : acc_step;
  assign finish = last_iter | early;
`else
  assign acc_d  = acc_step;
  assign finish = last_iter;
`endif

  // Controller and datapath registers. Operands are captured only on an
  // accept edge; DONE with out_ready and in_valid restarts directly into
  // CALC for back-to-back operation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      ovl_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q <= mcand_ext;
            mplr_q  <= mplr_ext;
            ovl_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mplr_q <= EW'($signed(mplr_q) >>> 2);
          ovl_q  <= mplr_q[1];
          cnt_q  <= cnt_q + CW'(1);
          if (finish) begin
            result_q <= acc_d[2*WIDTH-1:0];
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              mcand_q <= mcand_ext;
              mplr_q  <= mplr_ext;
              ovl_q   <= 1'b0;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_r4.sv
module tb_booth_mul_r4;

`ifdef BOOTH_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        mul_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  logic        nInValid;
  logic        nInReady;
  logic        nMulSigned;
  logic [7:0]  nSrc1;
  logic [7:0]  nSrc2;
  logic        nOutValid;
  logic        nOutReady;
  logic [15:0] nResult;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  booth_mul_r4 #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .src1       (src1),
    .src2       (src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result)
  );

  booth_mul_r4 #(.WIDTH(8)) dutNarrow (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (nInValid),
    .in_ready   (nInReady),
    .mul_signed (nMulSigned),
    .src1       (nSrc1),
    .src2       (nSrc2),
    .out_valid  (nOutValid),
    .out_ready  (nOutReady),
    .result     (nResult)
  );

  // Counts every comparison and reports any mismatch on a single line.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference product of the extended operands, truncated to 64 bits.
  function automatic logic [63:0] refProduct(input logic s, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Presents operands for one accept edge, then keeps in_valid high with
  // scrambled operands so that anything sampled during CALC would corrupt
  // the result.
  task automatic driveAccept(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mul_signed = s;
    src1       = a;
    src2       = b;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    mul_signed = ~s;
    src1       = ~a;
    src2       = b ^ 32'h5A5A_A5A5;
  endtask

  // Counts rising edges from the accept edge until out_valid, bounded.
  task automatic waitResult(input string tag, input logic [63:0] expected, input int expLat);
    int lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 200);
    in_valid = 1'b0;
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
    if (expLat >= 0) checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " result"}, result, expected);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] expected,
                               input int latFull, input int latEarly);
    driveAccept(s, a, b);
    waitResult(tag, expected, EARLY ? latEarly : latFull);
    releaseResult(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] held;
    int          nLat;

    resetn     = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    mul_signed = 1'b0;
    src1       = '0;
    src2       = '0;
    nInValid   = 1'b0;
    nOutReady  = 1'b0;
    nMulSigned = 1'b0;
    nSrc1      = '0;
    nSrc2      = '0;

    #12;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset result", result, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Directed vectors: tag, signed, src1, src2, product, latency (full / early)
    applyStimulus("u_max",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 17, 17);
    applyStimulus("s_minmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, 16);
    applyStimulus("s_m1x1",    1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 17, 1);
    applyStimulus("src2_zero", 1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0, 17, 1);
    applyStimulus("s_5xm1",    1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 17, 1);
    applyStimulus("s_3xm2",    1'b1, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 17, 1);
    applyStimulus("s_m1xm1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 17, 1);
    applyStimulus("u_pow2",    1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 17, 9);
    applyStimulus("u_x1",      1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 64'h0000_0000_DEAD_BEEF, 17, 1);
    applyStimulus("s_7xm3",    1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 17, 2);
    applyStimulus("u_minmin",  1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, 17);
    applyStimulus("u_maxx2",   1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 17, 2);

    // Backpressure: hold the result for five cycles, then release it in the
    // same cycle that new operands are offered.
    driveAccept(1'b1, 32'h0000_1234, 32'h0000_0010);
    waitResult("bp_first", 64'h0000_0000_0001_2340, EARLY ? 3 : 17);
    held = result;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("bp hold out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp hold result", result, held);
    checkOutput("bp hold in_ready", 64'(in_ready), 64'd0);
    out_ready  = 1'b1;
    mul_signed = 1'b1;
    src1       = 32'hFFFF_FFF0;
    src2       = 32'h0000_0100;
    in_valid   = 1'b1;
    #1;
    checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready  = 1'b0;
    src1       = 32'h0BAD_0BAD;
    src2       = 32'h0000_0003;
    mul_signed = 1'b0;
    checkOutput("bp reaccept out_valid", 64'(out_valid), 64'd0);
    waitResult("bp_second", 64'hFFFF_FFFF_FFFF_F000, EARLY ? 5 : 17);
    releaseResult("bp_second");

    // Reset in the middle of CALC abandons the operation.
    driveAccept(1'b0, 32'h1234_5678, 32'h8000_0000);
    repeat (7) @(posedge clk);
    #2;
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset result", result, 64'd0);
    checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus("post_reset", 1'b1, 32'h0000_0064, 32'hFFFF_FF9C, 64'hFFFF_FFFF_FFFF_D8F0, 17, 4);

    // Narrow instance: WIDTH=8, 0x7F * 0x81 signed.
    @(negedge clk);
    nMulSigned = 1'b1;
    nSrc1      = 8'h7F;
    nSrc2      = 8'h81;
    nInValid   = 1'b1;
    @(posedge clk);
    #1;
    nInValid = 1'b0;
    nSrc1    = 8'h00;
    nSrc2    = 8'h00;
    nLat     = 0;
    do begin
      @(posedge clk);
      nLat++;
      @(negedge clk);
    end while (!nOutValid && nLat < 50);
    checkOutput("narrow latency", 64'(nLat), EARLY ? 64'd4 : 64'd5);
    checkOutput("narrow result", 64'(nResult), 64'h0000_0000_0000_C0FF);
    nOutReady = 1'b1;
    @(posedge clk);
    #1;
    nOutReady = 1'b0;

    // Random operands against the reference product.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      driveAccept(rs, ra, rb);
      waitResult("random", refProduct(rs, ra, rb), -1);
      releaseResult("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/booth_mul_r4.md
BOOTH_MUL_R4 -- requirements
Module: booth_mul_r4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port mul_signed, input, 1 bit: 1 treats src1 and src2 as two's complement, 0 treats them as unsigned.
REQ-007 The block SHALL have port src1, input, WIDTH bits: multiplicand.
REQ-008 The block SHALL have port src2, input, WIDTH bits: multiplier, which is Booth-recoded.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, 2*WIDTH bits: the full product.

Function
REQ-012 Operands SHALL be sampled only on a rising edge where in_valid and in_ready are both 1 (the accept edge); at any other time, changes on src1, src2 and mul_signed SHALL be ignored.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 The FSM transitions SHALL be:
- IDLE to CALC on accept.
- CALC to DONE after the last iteration.
- DONE to IDLE on out_ready with no accept.
- DONE to CALC on out_ready together with an accept.
REQ-015 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready), giving back-to-back throughput.
REQ-016 out_valid SHALL be 1 exactly when state==DONE.
REQ-017 The multiplier SHALL be extended to WIDTH+2 bits, sign-extended when mul_signed=1 and zero-extended when mul_signed=0.
REQ-018 The multiplicand SHALL be extended in the same way, so that unsigned operands are handled without a separate path.
REQ-019 Each CALC cycle SHALL retire one radix-4 Booth digit in {-2,-1,0,+1,+2} from a 3-bit overlapping window.
REQ-020 The iteration count SHALL be K = WIDTH/2+1.
REQ-021 Without early termination, out_valid SHALL rise exactly K rising edges after the accept edge; for WIDTH=32 that is 17.
REQ-022 result SHALL equal the exact 2*WIDTH-bit product of the extended operands, truncated to 2*WIDTH bits.
REQ-023 result SHALL be held stable while out_valid=1 and out_ready=0, with no new accept taken during that time.
REQ-024 result SHALL keep its last value outside DONE; it is not required to read zero.
REQ-025 Asserting in_valid in CALC SHALL have no effect, because in_ready is 0 there.

Reset
REQ-026 While resetn=0, the block SHALL asynchronously force state=IDLE, out_valid=0, in_ready=1 and result=0, and SHALL clear all internal registers.
REQ-027 A reset in CALC or DONE SHALL abandon the operation with no output.
REQ-028 The first accept after reset SHALL be possible on the first rising edge after resetn deasserts.

Configuration
REQ-029 With macro BOOTH_MUL_EARLY_TERM_EN defined, CALC SHALL go to DONE at the first cycle where the remaining unretired multiplier bits, including the overlap bit, are all 0 or all 1.
REQ-030 In that case the remaining accumulator alignment SHALL be applied in the same cycle, so the result is bit-identical to the full computation.
REQ-031 With BOOTH_MUL_EARLY_TERM_EN defined, the minimum latency SHALL be 1 cycle, for example src2=0, or src2 all-ones with mul_signed=1.
REQ-032 With BOOTH_MUL_EARLY_TERM_EN undefined, latency SHALL always be K and no early-termination logic SHALL be present.

Structure
REQ-033 Package booth_mul_pkg SHALL hold:
- the state enum (IDLE/CALC/DONE);
- the Booth digit typedef (3-bit one-hot-style: neg, one, two);
- a constant function returning K for a given WIDTH.
REQ-034 Sub-module booth_r4_enc SHALL map the 3-bit window and the extended multiplicand to a (WIDTH+3)-bit partial product covering -2X to +2X, including the negate carry-in.
REQ-035 No other sub-modules SHALL be used.

Verification (WIDTH=32 unless stated)
REQ-036 Unsigned case: mul_signed=0, src1=src2=0xFFFFFFFF -> result 0xFFFFFFFE00000001, out_valid 17 edges after accept (macro off).
REQ-037 Signed cases:
- mul_signed=1, 0x80000000*0x80000000 -> 0x4000000000000000.
- mul_signed=1, 0xFFFFFFFF*0x00000001 -> 0xFFFFFFFFFFFFFFFF.
REQ-038 Backpressure:
- Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0.
- Then out_ready=1 with in_valid=1 in the same cycle -> new operands accepted on that edge.
REQ-039 Reset mid-operation: drop resetn at CALC iteration 8 -> out_valid=0 and result=0 immediately; after release, in_ready=1 and the next operation is correct.
REQ-040 Early termination:
- src2=0 -> latency 1 with BOOTH_MUL_EARLY_TERM_EN, 17 without.
- 10k random operands with random mul_signed -> every result matches the behavioural product under both builds.
REQ-041 Narrow width: WIDTH=8, mul_signed=1, 0x7F*0x81 -> result 0xC0FF, latency 5.
